// File: rtl/typing_pkg.sv
// Shared types and constants for the typing-test session controller.
// Pure declarations: no logic, no latency, no flow control.
package typing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int TEXT_LEN_DEFAULT = 64;
  localparam int BCD_W            = 4;

endpackage

// File: rtl/typing_test_ctrl_if.sv
// Request/keystroke/stopwatch bus between the session controller and its neighbours.
// Wires only; the controller registers every output and has no backpressure.
interface typing_test_ctrl_if #(
  parameter int CNT_W = 8
);
  import typing_pkg::*;

  logic             begin_req;
  logic             abort_req;
  logic             pause_req;
  logic             key_valid;
  logic             key_correct;
  logic             sw_at_end;
  logic [BCD_W-1:0] sw_deci;
  logic [BCD_W-1:0] sw_sec;
  logic [BCD_W-1:0] sw_deca;

  logic             sw_rst;
  logic             sw_start;
  logic [2:0]       state;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] correct_cnt;
  logic [CNT_W-1:0] error_cnt;
  logic [BCD_W-1:0] t_deci;
  logic [BCD_W-1:0] t_sec;
  logic [BCD_W-1:0] t_deca;

  modport slave (
    input  begin_req, abort_req, pause_req, key_valid, key_correct,
    input  sw_at_end, sw_deci, sw_sec, sw_deca,
    output sw_rst, sw_start, state, busy, done,
    output correct_cnt, error_cnt, t_deci, t_sec, t_deca
  );

  modport master (
    output begin_req, abort_req, pause_req, key_valid, key_correct,
    output sw_at_end, sw_deci, sw_sec, sw_deca,
    input  sw_rst, sw_start, state, busy, done,
    input  correct_cnt, error_cnt, t_deci, t_sec, t_deca
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != MAX)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/typing_test_ctrl.sv
// Typing-test session FSM: drives the stopwatch, counts keystrokes, snapshots elapsed time.
// All outputs registered, one cycle after the causing input; no backpressure (pulse inputs).
module typing_test_ctrl
  import typing_pkg::*;
#(
  parameter int TEXT_LEN = TEXT_LEN_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  typing_test_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   LEN_W   = (CNT_W+1)'(TEXT_LEN);

  state_e           r_state;
  logic             r_sw_rst;
  logic             r_sw_start;
  logic             r_busy;
  logic             r_done;
  logic [BCD_W-1:0] r_t_deci;
  logic [BCD_W-1:0] r_t_sec;
  logic [BCD_W-1:0] r_t_deca;

  state_e           w_nxt;
  logic             w_key_cnt;
  logic             w_inc_corr;
  logic             w_inc_err;
  logic             w_clr;
  logic             w_hit;
  logic             w_enter_done;
  logic [CNT_W-1:0] w_correct_cnt;
  logic [CNT_W-1:0] w_error_cnt;
  logic [CNT_W-1:0] w_corr_nx;
  logic [CNT_W-1:0] w_err_nx;
  logic [CNT_W:0]   w_sum;

  // A key counts in ARMED, or in RUN unless the stopwatch ran out this same cycle.
  assign w_key_cnt  = bus.key_valid && !bus.abort_req &&
                      ((r_state == ST_ARMED) || ((r_state == ST_RUN) && !bus.sw_at_end));
  assign w_inc_corr = w_key_cnt &&  bus.key_correct;
  assign w_inc_err  = w_key_cnt && !bus.key_correct;
  assign w_clr      = bus.abort_req ||
                      (bus.begin_req && ((r_state == ST_IDLE) || (r_state == ST_DONE)));

  assign w_corr_nx = (w_inc_corr && (w_correct_cnt != CNT_MAX)) ? w_correct_cnt + CNT_W'(1)
                                                                : w_correct_cnt;
  assign w_err_nx  = (w_inc_err && (w_error_cnt != CNT_MAX)) ? w_error_cnt + CNT_W'(1)
                                                             : w_error_cnt;
  assign w_sum     = {1'b0, w_corr_nx} + {1'b0, w_err_nx};
  assign w_hit     = (w_sum == LEN_W);

  always_comb begin
    w_nxt = r_state;
    if (bus.abort_req) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.begin_req) w_nxt = ST_ARMED;
        ST_ARMED:  if (bus.key_valid) w_nxt = w_hit ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (bus.sw_at_end)                 w_nxt = ST_DONE;
          else if (bus.key_valid && w_hit)   w_nxt = ST_DONE;
          else if (bus.pause_req)            w_nxt = ST_PAUSED;
        end
        ST_PAUSED: if (bus.pause_req) w_nxt = ST_RUN;
        ST_DONE:   if (bus.begin_req) w_nxt = ST_ARMED;
        default:   w_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_enter_done = (w_nxt == ST_DONE) && (r_state != ST_DONE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_sw_rst   <= 1'b1;
      r_sw_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_t_deci   <= '0;
      r_t_sec    <= '0;
      r_t_deca   <= '0;
    end else begin
      r_state    <= w_nxt;
      // Stopwatch is held clear in IDLE and for the first ARMED cycle only.
      r_sw_rst   <= (w_nxt == ST_IDLE) || ((w_nxt == ST_ARMED) && (r_state != ST_ARMED));
      r_sw_start <= (w_nxt == ST_RUN);
      r_busy     <= (w_nxt == ST_ARMED) || (w_nxt == ST_RUN) || (w_nxt == ST_PAUSED);
      r_done     <= w_enter_done;
      if (w_clr) begin
        r_t_deci <= '0;
        r_t_sec  <= '0;
        r_t_deca <= '0;
      end else if (w_enter_done) begin
        r_t_deci <= bus.sw_deci;
        r_t_sec  <= bus.sw_sec;
        r_t_deca <= bus.sw_deca;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_corr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_clr),
    .i_inc (w_inc_corr),
    .o_q   (w_correct_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_clr),
    .i_inc (w_inc_err),
    .o_q   (w_error_cnt)
  );

  assign bus.state       = r_state;
  assign bus.sw_rst      = r_sw_rst;
  assign bus.sw_start    = r_sw_start;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.correct_cnt = w_correct_cnt;
  assign bus.error_cnt   = w_error_cnt;
  assign bus.t_deci      = r_t_deci;
  assign bus.t_sec       = r_t_sec;
  assign bus.t_deca      = r_t_deca;

endmodule

// File: doc/typing_test_ctrl.md
# typing_test_ctrl

Session controller for the typing test. Sequences the `stopwatch` block: clears it, starts it on the first keystroke, pauses and resumes it, and stops it at completion or timeout. It also counts correct and erroneous keystrokes and snapshots the elapsed time. It sits between the keyboard/compare logic and the `stopwatch`, and feeds the score/display logic.

## Interface
- `TEXT_LEN`, default 64: number of keystrokes that completes a test (1..2^CNT_W-1).
- `CNT_W`, default 8: width of the keystroke counters.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `begin_req`  in  1  1-cycle pulse; arms a new test.
- `abort_req`  in  1  1-cycle pulse; cancels the session.
- `pause_req`  in  1  1-cycle pulse; toggles pause while a test runs.
- `key_valid`  in  1  1-cycle pulse per keystroke.
- `key_correct`  in  1  qualifies `key_valid`: 1 = matched expected char.
- `sw_at_end`  in  1  stopwatch reached its maximum count.
- `sw_deci`, `sw_sec`, `sw_deca`  in  4 each  live BCD digits from the stopwatch.
- `sw_rst`  out  1  active-high clear to the stopwatch.
- `sw_start`  out  1  level run-enable to the stopwatch.
- `state`  out  3  current state encoding.
- `busy`  out  1  high in ARMED, RUN, PAUSED.
- `done`  out  1  1-cycle pulse on entry to DONE.
- `correct_cnt`, `error_cnt`  out  CNT_W each  keystroke counts.
- `t_deci`, `t_sec`, `t_deca`  out  4 each  elapsed-time snapshot.

## Operation
- States: IDLE=0, ARMED=1, RUN=2, PAUSED=3, DONE=4.
- **IDLE**
  - `sw_rst`=1, `sw_start`=0.
  - `begin_req` → ARMED, and clears the counters and the snapshot.
- **ARMED**
  - `sw_rst`=0, `sw_start`=0.
  - The first `key_valid` is counted and moves to RUN.
  - `pause_req` is ignored.
- **RUN**
  - `sw_start`=1.
  - Each `key_valid` increments `correct_cnt` if `key_correct`=1, else `error_cnt`.
  - When correct+error (after this cycle's increment) equals `TEXT_LEN` → DONE.
  - `sw_at_end` → DONE.
  - `pause_req` → PAUSED.
- **PAUSED**
  - `sw_start`=0; keys are ignored.
  - `pause_req` → RUN.
  - `sw_at_end` is ignored.
- **DONE**
  - `sw_start`=0, `sw_rst`=0, so the stopwatch holds its value.
  - Snapshot registers hold their values.
  - `begin_req` → ARMED, which clears the counters and the snapshot, with `sw_rst` pulsed.
- **Abort:** `abort_req` in any state → IDLE, with counters and snapshot cleared.
- **Priority within one cycle:** `abort_req` > `sw_at_end` > `key_valid` > `pause_req` > `begin_req`.
  - Key and `sw_at_end` together in RUN: the key is NOT counted; the state goes to DONE.
  - Key and `pause_req` together in RUN: the key is counted; the state goes to PAUSED, unless the count completes, in which case DONE.
- **Counters** saturate at 2^CNT_W-1 and never wrap.
- **Snapshot:** on the transition into DONE, `t_*` latch the `sw_*` values present in that same cycle.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE, `sw_rst`=1, `sw_start`=0, `busy`=0, `done`=0.
  - Counters = 0, `t_*` = 0.
- **Entering ARMED:**
  - `sw_rst`=1 for exactly the first ARMED cycle, then 0.
  - This applies from IDLE (where it is already 1) and from DONE (a 1-cycle pulse).
- **First key:** a key in ARMED at cycle N gives RUN and `sw_start`=1 at N+1; the count is visible at N+1.
- **Pause/resume:** `pause_req` at cycle N gives `sw_start` toggled at N+1.
- **Completion:** completing key or `sw_at_end` at cycle N gives DONE, `done`=1 and `sw_start`=0 at N+1, with `done` low at N+2.
- **Snapshot skew:** the stopwatch may advance one tick during cycle N. This single-tick skew is accepted.
- **Reset mid-test:** asserting `rst` forces the reset values immediately, independent of `clk`.

## Structure
- Shared package `typing_pkg`:
  - state encodings (IDLE..DONE, 3-bit);
  - `TEXT_LEN_DEFAULT`;
  - BCD digit width constant (4).
- One sub-module, `sat_counter`:
  - parameter `W`;
  - inputs `clk`, `rst`, `clr`, `inc`;
  - output `q`, saturating;
  - instantiated twice, for `correct_cnt` and `error_cnt`.
- The FSM, output registers and snapshot live in the top module.

## Test plan
- **Reset then full run:** reset; `begin_req`; 64 keys, all `key_correct`=1.
  - `sw_start` rises the cycle after key 1.
  - `done` pulses the cycle after key 64; `correct_cnt`=64, `error_cnt`=0.
  - `t_*` equal the `sw_*` values at the key-64 cycle.
- **Mixed keys:** 50 correct and 14 wrong keys → DONE with `correct_cnt`=50, `error_cnt`=14.
- **Timeout race:** in RUN at 10 keys, drive `sw_at_end`=1 together with `key_valid`.
  - DONE, `correct_cnt`=10 (the key is dropped), `sw_start`=0 next cycle.
- **Pause:** `pause_req` in RUN, then 5 keys, then `pause_req`.
  - Counts unchanged during the pause; `sw_start` is 0 and then 1, each one cycle after its request.
  - `sw_at_end` during the pause does not end the test.
- **Abort and reset:**
  - `abort_req` in PAUSED → IDLE, `sw_rst`=1, counters 0.
  - Async `rst` low mid-RUN → all reset values without a clock edge.
- **Restart and saturation:**
  - Restart from DONE gives a 1-cycle `sw_rst` pulse and counters 0.
  - With CNT_W=4 and TEXT_LEN=15, 20 wrong keys in RUN leave `error_cnt` saturated at 15, and DONE is reached.
